// File: rtl/layer_compositor.sv
// Final video stage: aligns sync/foreground with the background memory latency, merges layers by
// fixed priority (UI > object > background) and applies a frame-synchronous global fade.
module layer_compositor #(
  parameter int unsigned BG_LAT          = 1,
  parameter int unsigned FRAMES_PER_STEP = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [11:0] bg_pixel,
  input  logic [11:0] obj_pixel,
  input  logic        obj_en,
  input  logic [11:0] ui_pixel,
  input  logic        ui_en,
  input  logic [1:0]  fade_req,
  output logic        fade_busy,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        hsync,
  output logic        vsync
);

  typedef enum logic [1:0] {StShown, StFadeOut, StHidden, StFadeIn} state_e;

  localparam int unsigned Last = BG_LAT - 1;
  localparam logic [3:0] StepLast = 4'(FRAMES_PER_STEP - 1);

  // Stage A delay line
  logic [BG_LAT-1:0] a_valid_q, a_hs_q, a_vs_q, a_obj_en_q, a_ui_en_q;
  logic [11:0]       a_obj_q [BG_LAT];
  logic [11:0]       a_ui_q  [BG_LAT];

  // Stage B
  logic [11:0] mix_d, mix_q;
  logic        b_hs_q, b_vs_q;

  // Fade control
  state_e     state_q;
  logic [4:0] level_q;
  logic [3:0] cnt_q;
  logic       vs_prev_q;
  logic       tick;
  logic       step;

  logic [8:0] prod_r, prod_g, prod_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_valid_q  <= '0;
      a_hs_q     <= '1;
      a_vs_q     <= '1;
      a_obj_en_q <= '0;
      a_ui_en_q  <= '0;
      for (int i = 0; i < BG_LAT; i++) begin
        a_obj_q[i] <= '0;
        a_ui_q[i]  <= '0;
      end
    end else begin
      a_valid_q[0]  <= valid;
      a_hs_q[0]     <= hsync_in;
      a_vs_q[0]     <= vsync_in;
      a_obj_en_q[0] <= obj_en;
      a_ui_en_q[0]  <= ui_en;
      a_obj_q[0]    <= obj_pixel;
      a_ui_q[0]     <= ui_pixel;
      for (int i = 1; i < BG_LAT; i++) begin
        a_valid_q[i]  <= a_valid_q[i-1];
        a_hs_q[i]     <= a_hs_q[i-1];
        a_vs_q[i]     <= a_vs_q[i-1];
        a_obj_en_q[i] <= a_obj_en_q[i-1];
        a_ui_en_q[i]  <= a_ui_en_q[i-1];
        a_obj_q[i]    <= a_obj_q[i-1];
        a_ui_q[i]     <= a_ui_q[i-1];
      end
    end
  end

  always_comb begin
    mix_d = bg_pixel;
    if (!a_valid_q[Last]) begin
      mix_d = '0;
    end else if (a_ui_en_q[Last]) begin
      mix_d = a_ui_q[Last];
    end else if (a_obj_en_q[Last]) begin
      mix_d = a_obj_q[Last];
    end
  end

  always_comb begin
    prod_r = {5'd0, mix_q[11:8]} * {4'd0, level_q};
    prod_g = {5'd0, mix_q[7:4]}  * {4'd0, level_q};
    prod_b = {5'd0, mix_q[3:0]}  * {4'd0, level_q};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mix_q  <= '0;
      b_hs_q <= 1'b1;
      b_vs_q <= 1'b1;
      vga_r  <= '0;
      vga_g  <= '0;
      vga_b  <= '0;
      hsync  <= 1'b1;
      vsync  <= 1'b1;
    end else begin
      mix_q  <= mix_d;
      b_hs_q <= a_hs_q[Last];
      b_vs_q <= a_vs_q[Last];
      vga_r  <= prod_r[7:4];
      vga_g  <= prod_g[7:4];
      vga_b  <= prod_b[7:4];
      hsync  <= b_hs_q;
      vsync  <= b_vs_q;
    end
  end

  // Frame tick on the falling edge of raw vsync; level only moves here so a frame has one level.
  assign tick = vs_prev_q & ~vsync_in;
  assign step = tick && (cnt_q == StepLast);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StShown;
      level_q   <= 5'd16;
      cnt_q     <= '0;
      vs_prev_q <= 1'b1;
      fade_busy <= 1'b0;
    end else begin
      vs_prev_q <= vsync_in;
      unique case (state_q)
        StShown: begin
          if (fade_req == 2'b01) begin
            state_q   <= StFadeOut;
            cnt_q     <= '0;
            fade_busy <= 1'b1;
          end
        end
        StHidden: begin
          if (fade_req == 2'b10) begin
            state_q   <= StFadeIn;
            cnt_q     <= '0;
            fade_busy <= 1'b1;
          end
        end
        StFadeOut: begin
          if (step) begin
            cnt_q   <= '0;
            level_q <= level_q - 5'd1;
            if (level_q == 5'd1) begin
              state_q   <= StHidden;
              fade_busy <= 1'b0;
            end
          end else if (tick) begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        StFadeIn: begin
          if (step) begin
            cnt_q   <= '0;
            level_q <= level_q + 5'd1;
            if (level_q == 5'd15) begin
              state_q   <= StShown;
              fade_busy <= 1'b0;
            end
          end else if (tick) begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        default: state_q <= StShown;
      endcase
    end
  end

endmodule

// File: tb/tb_layer_compositor.sv
// Directed bench for layer_compositor: priority/blanking vector table plus latency, fade and
// asynchronous reset sequences.
module tb_layer_compositor;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid, hsync_in, vsync_in, obj_en, ui_en;
  logic [11:0] bg_pixel, obj_pixel, ui_pixel;
  logic [1:0]  fade_req;
  logic        fade_busy, hsync, vsync;
  logic [3:0]  vga_r, vga_g, vga_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  layer_compositor #(
    .BG_LAT          (1),
    .FRAMES_PER_STEP (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .valid     (valid),
    .hsync_in  (hsync_in),
    .vsync_in  (vsync_in),
    .bg_pixel  (bg_pixel),
    .obj_pixel (obj_pixel),
    .obj_en    (obj_en),
    .ui_pixel  (ui_pixel),
    .ui_en     (ui_en),
    .fade_req  (fade_req),
    .fade_busy (fade_busy),
    .vga_r     (vga_r),
    .vga_g     (vga_g),
    .vga_b     (vga_b),
    .hsync     (hsync),
    .vsync     (vsync)
  );

  typedef struct {
    string       name;
    logic        v;
    logic [11:0] bg;
    logic [11:0] obj;
    logic        oen;
    logic [11:0] ui;
    logic        uen;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int rgb();
    return {vga_r, vga_g, vga_b};
  endfunction

  task automatic set_pix(input logic v, input logic [11:0] bg, input logic [11:0] obj,
                         input logic oen, input logic [11:0] ui, input logic uen);
    valid = v; bg_pixel = bg; obj_pixel = obj; obj_en = oen; ui_pixel = ui; ui_en = uen;
  endtask

  // hsync_in falls at cycle N with bg presented at N+1; output must appear exactly at N+3.
  task automatic lat_seq(input string name, input logic v, input logic [11:0] bg,
                         input logic [11:0] exp);
    set_pix(v, 12'h000, 12'hFFF, 1'b1 & ~v, 12'h000, 1'b0);
    hsync_in = 1'b1;
    step(4);
    hsync_in = 1'b0;
    step();
    hsync_in = 1'b1;
    bg_pixel = bg;
    step();
    check({name, "_hs_early"}, hsync, 1);
    check({name, "_rgb_early"}, rgb(), 0);
    step();
    check({name, "_hs"}, hsync, 0);
    check({name, "_rgb"}, rgb(), exp);
    step();
    check({name, "_hs_after"}, hsync, 1);
  endtask

  task automatic vs_fall(input int n);
    for (int i = 0; i < n; i++) begin
      vsync_in = 1'b0;
      step();
      vsync_in = 1'b1;
      step(2);
    end
  endtask

  task automatic pulse_req(input logic [1:0] r);
    fade_req = r;
    step();
    fade_req = 2'b00;
  endtask

  initial begin
    vecs[0] = '{"prio_ui",  1'b1, 12'h112, 12'hF00, 1'b1, 12'h0F0, 1'b1, 12'h0F0};
    vecs[1] = '{"prio_obj", 1'b1, 12'h112, 12'hF00, 1'b1, 12'h0F0, 1'b0, 12'hF00};
    vecs[2] = '{"prio_bg",  1'b1, 12'h112, 12'hF00, 1'b0, 12'h0F0, 1'b0, 12'h112};
    vecs[3] = '{"blank",    1'b0, 12'h112, 12'hFFF, 1'b1, 12'h0F0, 1'b0, 12'h000};
    vecs[4] = '{"blank_ui", 1'b0, 12'h123, 12'hFFF, 1'b1, 12'hFFF, 1'b1, 12'h000};
    vecs[5] = '{"ui_only",  1'b1, 12'h345, 12'h000, 1'b0, 12'hABC, 1'b1, 12'hABC};

    rst = 1'b1;
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    fade_req = 2'b00;
    set_pix(1'b1, 12'hAAA, 12'hFFF, 1'b1, 12'hFFF, 1'b1);
    step(2);
    check("rst_rgb", rgb(), 0);
    check("rst_hsync", hsync, 1);
    check("rst_vsync", vsync, 1);
    check("rst_busy", fade_busy, 0);
    rst = 1'b0;

    lat_seq("lat", 1'b1, 12'h122, 12'h122);
    lat_seq("blank_sync", 1'b0, 12'h122, 12'h000);

    foreach (vecs[i]) begin
      set_pix(vecs[i].v, vecs[i].bg, vecs[i].obj, vecs[i].oen, vecs[i].ui, vecs[i].uen);
      step(4);
      check(vecs[i].name, rgb(), int'(vecs[i].exp));
    end

    // Fade out
    set_pix(1'b1, 12'hAAA, 12'h000, 1'b0, 12'h000, 1'b0);
    step(4);
    check("pre_fade", rgb(), 12'hAAA);
    pulse_req(2'b01);
    check("fo_busy_rise", fade_busy, 1);
    vs_fall(2);
    step(2);
    check("fo_lvl15", rgb(), 12'h999);
    vs_fall(29);
    check("fo_busy_31", fade_busy, 1);
    vs_fall(1);
    step(2);
    check("fo_done_rgb", rgb(), 0);
    check("fo_done_busy", fade_busy, 0);
    pulse_req(2'b01);
    check("hidden_ign_01", fade_busy, 0);
    vs_fall(4);
    check("hidden_rgb", rgb(), 0);

    // Fade in, with an ignored reversal request
    pulse_req(2'b10);
    check("fi_busy_rise", fade_busy, 1);
    step();
    pulse_req(2'b01);
    vs_fall(4);
    step(2);
    check("fi_lvl2", rgb(), 12'h111);
    check("fi_busy_mid", fade_busy, 1);
    vs_fall(28);
    step(2);
    check("fi_done_rgb", rgb(), 12'hAAA);
    check("fi_done_busy", fade_busy, 0);

    // Reset mid-fade at level 7
    pulse_req(2'b01);
    vs_fall(18);
    step(2);
    check("lvl7_rgb", rgb(), 12'h444);
    hsync_in = 1'b0;
    step(4);
    check("pre_rst_hs", hsync, 0);
    #2;
    rst = 1'b1;
    #1;
    check("arst_busy", fade_busy, 0);
    check("arst_rgb", rgb(), 0);
    check("arst_hs", hsync, 1);
    check("arst_vs", vsync, 1);
    step();
    rst = 1'b0;
    hsync_in = 1'b1;
    step(4);
    check("post_rst_rgb", rgb(), 12'hAAA);
    check("post_rst_busy", fade_busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/layer_compositor.md
Name: layer_compositor

Overview:
- Final video stage, directly downstream of the background layer. Merges the background pixel with object and UI layer pixels by fixed priority and applies a frame-synchronous global fade.
- Drives the VGA RGB/sync pins.
- Delays sync, active-video and foreground inputs so they line up with the background block-memory read latency. Output is glitch-free with respect to frame boundaries.

Parameters:
- BG_LAT, 1, cycles from h_cnt/v_cnt presentation to valid bg_pixel (background memory read latency); legal 1..4.
- FRAMES_PER_STEP, 2, frames per fade-level step; legal 1..15.

Ports:
- clk  input  1  pixel clock
- rst  input  1  asynchronous active-high reset
- valid  input  1  active-video flag, aligned with h_cnt/v_cnt
- hsync_in  input  1  horizontal sync, active-low, aligned with h_cnt/v_cnt
- vsync_in  input  1  vertical sync, active-low, aligned with h_cnt/v_cnt
- bg_pixel  input  12  background RGB444, valid BG_LAT cycles after its coordinate
- obj_pixel  input  12  object-layer RGB444, aligned with h_cnt/v_cnt
- obj_en  input  1  object pixel opaque, aligned with h_cnt/v_cnt
- ui_pixel  input  12  UI-layer RGB444, aligned with h_cnt/v_cnt
- ui_en  input  1  UI pixel opaque, aligned with h_cnt/v_cnt
- fade_req  input  2  01 = fade out, 10 = fade in, 00/11 = none; sampled every cycle
- fade_busy  output  1  high while a fade is in progress
- vga_r  output  4  red
- vga_g  output  4  green
- vga_b  output  4  blue
- hsync  output  1  delayed hsync_in
- vsync  output  1  delayed vsync_in

Behaviour:
- Reset values (async, immediate):
  - vga_r/g/b = 0; hsync = vsync = 1; fade_busy = 0.
  - Fade level = 16; state = SHOWN.
  - All delay-line stages: valid = 0, syncs = 1, en = 0, pixels = 0.
- Pipeline:
  - Stage A: a BG_LAT-deep shift register carries valid, hsync_in, vsync_in, obj_pixel, obj_en, ui_pixel, ui_en, aligning them with bg_pixel.
  - Stage B (registered): mix = ui_en ? ui_pixel : obj_en ? obj_pixel : bg_pixel; forced to 0 if the delayed valid is 0.
  - Stage C (registered): each 4-bit channel c is computed as out = (c * level) >> 4, with level 5-bit, 0..16. Intermediate width is 9 bits; level 16 passes c unchanged; level 0 gives 0.
  - Syncs travel through the same stages.
- Total latency from input to vga_*/hsync/vsync is BG_LAT+2 cycles, identical for pixels and syncs.
- Frame tick: falling edge of raw vsync_in (registered compare against the previous value). One tick per frame.
- Step counter: 4-bit, counts ticks while fading. A level step occurs on the tick where counter == FRAMES_PER_STEP-1; the counter then clears. The counter is cleared on entering any fade state.
- Fade FSM states:
  - SHOWN (level 16): fade_req==01 -> FADE_OUT. All other requests are ignored.
  - FADE_OUT: on each step, level -= 1. When level reaches 0 -> HIDDEN.
  - HIDDEN (level 0): fade_req==10 -> FADE_IN. All other requests are ignored.
  - FADE_IN: on each step, level += 1. When level reaches 16 -> SHOWN.
- fade_req is ignored in FADE_OUT and FADE_IN (no reversal mid-fade). 11 is ignored in all states.
- Level changes only on a frame tick, so a frame is never rendered at two levels. The new level applies to Stage C from the cycle after the tick.
- fade_busy = 1 in FADE_OUT and FADE_IN, registered. It rises the cycle after the accepted request and falls the cycle after the final level step.
- Full fade duration is 16*FRAMES_PER_STEP frames.
- Reset asserted mid-fade: immediately returns to SHOWN at level 16 and clears the pipeline; no partial state survives.
- valid low: RGB is 0 regardless of layer enables or level. Syncs are still delayed normally.

Test Plan:
- Latency/alignment, BG_LAT=1, level 16: present valid=1, hsync_in falling at cycle N, bg_pixel=12'h122 at N+1, obj_en=ui_en=0 -> vga_r/g/b = 1/2/2 and hsync low both at cycle N+3.
- Priority: bg=12'h112, obj_pixel=12'hF00 with obj_en=1, ui_pixel=12'h0F0 with ui_en=1 -> output 0/F/0. With ui_en=0 -> F/0/0. With obj_en=0 as well -> 1/1/2.
- Blanking: valid=0, obj_en=1, obj_pixel=12'hFFF -> output 0/0/0 while syncs still toggle with BG_LAT+2 delay.
- Fade out, FRAMES_PER_STEP=2, constant pixel 12'hAAA:
  - Pulse fade_req=01 -> fade_busy=1 next cycle.
  - After 2 vsync falls: level 15, output 9/9/9 (10*15>>4).
  - After 32 falls: output 0/0/0, fade_busy=0, state HIDDEN.
  - A fade_req=01 pulse is then ignored.
- Fade in from HIDDEN: pulse fade_req=10; during the fade pulse fade_req=01 -> ignored. After 32 vsync falls, level 16, output A/A/A, fade_busy=0.
- Async reset mid-fade: assert rst at level 7, between clock edges -> fade_busy=0, vga_* = 0, hsync=vsync=1 immediately. After release, a pixel 12'hAAA emerges as A/A/A (level 16).
